// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: accepts one EX result per handshake, performs the load read, commits to the register file.
// Optional bypass port toward operand selection is enabled by defining WB_FWD_EN.
module wb_commit_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic [1:0]      in_wb_sel,
    input  logic [1:0]      in_mem_size,
    input  logic            in_mem_unsigned,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [1:0]      dreq_size,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            wb_wen,
    output logic [4:0]      wb_waddr,
    output logic [XLEN-1:0] wb_wdata,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc
`ifdef WB_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;

    state_t          state_q, state_d;
    logic [XLEN-1:0] alu_q, pc_q, load_q;
    logic [4:0]      rd_q;
    logic            wen_q, uns_q;
    logic [1:0]      sel_q, size_q;
    logic            accept;
    logic [XLEN-1:0] raw, load_ext;

    assign in_ready = (state_q != LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (in_wb_sel == SEL_MEM) ? LOAD : COMMIT;
            LOAD:    if (dresp_data_ok) state_d = COMMIT;
            COMMIT:  state_d = !in_valid ? IDLE : ((in_wb_sel == SEL_MEM) ? LOAD : COMMIT);
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Shift the addressed bytes down, then truncate and extend per access size.
    always_comb begin
        raw      = dresp_data >> {alu_q[2:0], 3'b000};
        load_ext = raw;
        case (size_q)
            2'd0:    load_ext = {{(XLEN-8){~uns_q & raw[7]}},   raw[7:0]};
            2'd1:    load_ext = {{(XLEN-16){~uns_q & raw[15]}}, raw[15:0]};
            2'd2:    load_ext = {{(XLEN-32){~uns_q & raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    // NOTE: these are plain registers, not a memory array; resetting them keeps every data output at zero after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_q  <= '0;
            pc_q   <= '0;
            rd_q   <= '0;
            wen_q  <= 1'b0;
            sel_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
            load_q <= '0;
        end else begin
            if (accept) begin
                alu_q  <= in_alu_result;
                pc_q   <= in_pc;
                rd_q   <= in_rd;
                wen_q  <= in_wen;
                sel_q  <= in_wb_sel;
                size_q <= in_mem_size;
                uns_q  <= in_mem_unsigned;
            end
            if (state_q == LOAD && dresp_data_ok) load_q <= load_ext;
        end
    end

    assign dreq_valid   = (state_q == LOAD);
    assign dreq_addr    = alu_q;
    assign dreq_size    = size_q;
    assign commit_valid = (state_q == COMMIT);
    assign commit_pc    = pc_q;
    assign wb_wen       = commit_valid && wen_q && (rd_q != 5'd0);
    assign wb_waddr     = rd_q;

    always_comb begin
        wb_wdata = '0;
        case (sel_q)
            SEL_ALU: wb_wdata = alu_q;
            SEL_MEM: wb_wdata = load_q;
            SEL_PC4: wb_wdata = pc_q + XLEN'(4);
            default: wb_wdata = '0;
        endcase
    end

`ifdef WB_FWD_EN
    assign fwd_valid = wb_wen;
    assign fwd_rd    = wb_waddr;
    assign fwd_data  = wb_wdata;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed vectors, a spec-level expectation queue,
// and one per-cycle compare process; literal expectations pin the model on the test-plan cases.
module tb_wb_commit_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            resetn;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic [1:0]      in_wb_sel;
    logic [1:0]      in_mem_size;
    logic            in_mem_unsigned;
    logic            dreq_valid;
    logic [XLEN-1:0] dreq_addr;
    logic [1:0]      dreq_size;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;
    logic            wb_wen;
    logic [4:0]      wb_waddr;
    logic [XLEN-1:0] wb_wdata;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
`ifdef WB_FWD_EN
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
`endif

    wb_commit_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
        .in_wb_sel(in_wb_sel), .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [63:0] pc;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        bit          has_lit;
        logic [63:0] lit;
    } exp_t;

    exp_t        exp_q[$];
    bit          chk_en   = 1'b0;
    bit          exp_dreq = 1'b0;
    logic [63:0] exp_addr = '0;
    logic [1:0]  exp_size = '0;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Value the instruction must write, straight from the select and load-extraction rules.
    function automatic logic [63:0] model_value(input logic [1:0] sel, input logic [63:0] alu,
                                                input logic [63:0] pc, input logic [1:0] size,
                                                input logic uns, input logic [63:0] data);
        logic [63:0] v, mask;
        int          nbits;
        case (sel)
            2'd0: return alu;
            2'd2: return pc + 64'd4;
            2'd3: return 64'd0;
            default: begin
                nbits = 8 << size;
                mask  = (size == 2'd3) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
                v     = (data >> (8 * alu[2:0])) & mask;
                if (!uns && size != 2'd3 && v[nbits-1]) v = v | ~mask;
                return v;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   exp_commit;
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("commit_missed_cycle", 64'(exp_q[0].cyc), 64'(cyc));
                void'(exp_q.pop_front());
            end
            exp_commit = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("in_ready", 64'(in_ready), 64'(!exp_dreq));
            check("dreq_valid", 64'(dreq_valid), 64'(exp_dreq));
            if (exp_dreq) begin
                check("dreq_addr", dreq_addr, exp_addr);
                check("dreq_size", 64'(dreq_size), 64'(exp_size));
            end
            check("commit_valid", 64'(commit_valid), 64'(exp_commit));
            if (exp_commit) begin
                e = exp_q.pop_front();
                check("commit_pc", commit_pc, e.pc);
                check("wb_wen", 64'(wb_wen), 64'(e.wen && e.rd != 5'd0));
                if (e.wen && e.rd != 5'd0) begin
                    check("wb_waddr", 64'(wb_waddr), 64'(e.rd));
                    check("wb_wdata", wb_wdata, e.data);
                    if (e.has_lit) check("wb_wdata_literal", wb_wdata, e.lit);
                end
`ifdef WB_FWD_EN
                check("fwd_valid", 64'(fwd_valid), 64'(e.wen && e.rd != 5'd0));
                if (e.wen && e.rd != 5'd0) begin
                    check("fwd_rd", 64'(fwd_rd), 64'(e.rd));
                    check("fwd_data", fwd_data, e.data);
                end
`endif
            end else begin
                check("wb_wen_idle", 64'(wb_wen), 64'd0);
`ifdef WB_FWD_EN
                check("fwd_valid_idle", 64'(fwd_valid), 64'd0);
`endif
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction; for loads, answer after k LOAD cycles (k counts the data_ok cycle).
    task automatic do_op(input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] pc,
                         input logic [4:0] rd, input logic wen, input logic [1:0] size,
                         input logic uns, input int k, input logic [63:0] data,
                         input bit has_lit, input logic [63:0] lit);
        exp_t e;
        in_valid        = 1'b1;
        in_wb_sel       = sel;
        in_alu_result   = alu;
        in_pc           = pc;
        in_rd           = rd;
        in_wen          = wen;
        in_mem_size     = size;
        in_mem_unsigned = uns;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        in_alu_result = ~alu;
        in_pc         = ~pc;
        e.cyc     = cyc + ((sel == 2'd1) ? k : 0);
        e.pc      = pc;
        e.wen     = wen;
        e.rd      = rd;
        e.data    = model_value(sel, alu, pc, size, uns, data);
        e.has_lit = has_lit;
        e.lit     = lit;
        exp_q.push_back(e);
        if (sel == 2'd1) begin
            exp_dreq   = 1'b1;
            exp_addr   = alu;
            exp_size   = size;
            dresp_data = ~data;
            repeat (k - 1) begin
                @(posedge clk);
                #1;
            end
            dresp_data_ok = 1'b1;
            dresp_data    = data;
            @(posedge clk);
            #1;
            dresp_data_ok = 1'b0;
            dresp_data    = ~data;
            exp_dreq      = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        resetn          = 1'b0;
        in_valid        = 1'b0;
        in_alu_result   = 64'h1111;
        in_pc           = 64'h2222;
        in_rd           = 5'd3;
        in_wen          = 1'b1;
        in_wb_sel       = 2'd0;
        in_mem_size     = 2'd0;
        in_mem_unsigned = 1'b0;
        dresp_data_ok   = 1'b0;
        dresp_data      = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst_wb_wen", 64'(wb_wen), 64'd0);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_wb_wdata", wb_wdata, 64'd0);
        check("rst_commit_pc", commit_pc, 64'd0);
        check("rst_dreq_addr", dreq_addr, 64'd0);
        check("rst_wb_waddr", 64'(wb_waddr), 64'd0);
`ifdef WB_FWD_EN
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
`endif
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;
        idle(1);

        do_op(2'd0, 64'h1234, 64'h100, 5'd5, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h1234);
        idle(2);
        do_op(2'd0, 64'h11, 64'h104, 5'd1, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h11);
        do_op(2'd0, 64'h22, 64'h108, 5'd2, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h22);
        do_op(2'd0, 64'h33, 64'h10c, 5'd3, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h33);
        idle(1);

        do_op(2'd1, 64'h1003, 64'h200, 5'd7, 1'b1, 2'd0, 1'b0, 3, 64'h0000_0000_8000_0000,
              1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        idle(1);
        do_op(2'd1, 64'h2006, 64'h204, 5'd8, 1'b1, 2'd1, 1'b1, 1, 64'hBEEF_0000_0000_0000,
              1'b1, 64'h0000_0000_0000_BEEF);
        do_op(2'd1, 64'h2006, 64'h208, 5'd9, 1'b1, 2'd1, 1'b0, 2, 64'hBEEF_0000_0000_0000,
              1'b1, 64'hFFFF_FFFF_FFFF_BEEF);
        idle(1);

        do_op(2'd2, 64'h0, 64'h8000_0000, 5'd0, 1'b1, 2'd0, 1'b0, 0, '0, 1'b0, '0);
        do_op(2'd2, 64'h0, 64'h8000_0000, 5'd1, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h8000_0004);
        idle(1);

        do_op(2'd1, 64'h1004, 64'h300, 5'd10, 1'b1, 2'd2, 1'b0, 2, 64'h8765_4321_0000_0000,
              1'b1, 64'hFFFF_FFFF_8765_4321);
        do_op(2'd1, 64'h1004, 64'h304, 5'd11, 1'b1, 2'd2, 1'b1, 1, 64'h8765_4321_0000_0000,
              1'b1, 64'h0000_0000_8765_4321);
        do_op(2'd1, 64'h1000, 64'h308, 5'd12, 1'b1, 2'd3, 1'b0, 4, 64'hF123_4567_89AB_CDEF,
              1'b1, 64'hF123_4567_89AB_CDEF);
        do_op(2'd3, 64'hDEAD, 64'h30c, 5'd13, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h0);
        do_op(2'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd14, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h0);
        do_op(2'd0, 64'h77, 64'h310, 5'd4, 1'b0, 2'd0, 1'b0, 0, '0, 1'b0, '0);
        idle(1);

        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        idle(2);
        do_op(2'd0, 64'h99, 64'h400, 5'd15, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h99);
        dresp_data_ok = 1'b0;
        idle(1);

        in_valid        = 1'b1;
        in_wb_sel       = 2'd1;
        in_alu_result   = 64'h3000;
        in_pc           = 64'h500;
        in_rd           = 5'd16;
        in_wen          = 1'b1;
        in_mem_size     = 2'd3;
        in_mem_unsigned = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_dreq = 1'b1;
        exp_addr = 64'h3000;
        exp_size = 2'd3;
        idle(1);
        chk_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        exp_dreq = 1'b0;
        check("midload_rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("midload_rst_in_ready", 64'(in_ready), 64'd1);
        check("midload_rst_commit_valid", 64'(commit_valid), 64'd0);
        check("midload_rst_dreq_addr", dreq_addr, 64'd0);
`ifdef WB_FWD_EN
        check("midload_rst_fwd_valid", 64'(fwd_valid), 64'd0);
`endif
        @(posedge clk);
        #1;
        resetn        = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk);
        #1;
        dresp_data_ok = 1'b0;
        check("post_rst_commit_pc", commit_pc, 64'd0);
        chk_en = 1'b1;
        idle(3);

        do_op(2'd0, 64'h55, 64'h10, 5'd6, 1'b1, 2'd0, 1'b0, 0, '0, 1'b1, 64'h55);
        idle(3);
        check("expectations_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
